button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
- Consumes the clean level produced by the delayed debouncer and classifies button activity into single-cycle event pulses: raw press/release edges, short press, long press and double click.
- Sits directly downstream of the debouncer and feeds control logic with one-shot strobes, so consumers never handle level or timing logic.
- The FSM and a shared duration counter run in the debouncer's clock domain.

Parameters:
- LONG_CYCLES, 100_000_000: consecutive high cycles that classify a press as long (1 s at 100 MHz); must be >= 2.
- GAP_CYCLES, 25_000_000: maximum low cycles after a short release in which a second press makes a double click; must be >= 2.
- CNT_W, $clog2(max(LONG_CYCLES, GAP_CYCLES)) + 1: duration counter width; derived, never overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- btn_level  input  1  debounced button level, already synchronous to clk; 1 = pressed.
- press_edge  output  1  one-cycle pulse on each 0->1 of btn_level.
- release_edge  output  1  one-cycle pulse on each 1->0 of btn_level.
- short_press  output  1  one-cycle pulse for a single press shorter than LONG_CYCLES with no second press within GAP_CYCLES.
- long_press  output  1  one-cycle pulse when a press reaches LONG_CYCLES of continuous high.
- double_click  output  1  one-cycle pulse on release of a second short press that started within GAP_CYCLES of the first release.
- busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, counter = 0, all pulse outputs = 0, busy = 0.
  - btn_q (previous-sample register) = 1. A button held through reset release yields no press_edge and no event until it is released and pressed again.
- Edge detect: rise = btn_level & ~btn_q; fall = ~btn_level & btn_q. btn_q <= btn_level every cycle.
- All outputs are registered. Each pulse is high for exactly one cycle, in the cycle after the clock edge at which its condition was sampled.
- press_edge and release_edge follow rise and fall in every state, independent of the FSM.
- IDLE:
  - rise -> PRESSED, counter <= 1.
- PRESSED:
  - btn high and counter == LONG_CYCLES-1 -> long_press, LONG_HELD.
  - btn high otherwise -> counter++.
  - fall -> WAIT_GAP, counter <= 1.
- LONG_HELD:
  - fall -> IDLE, no pulse.
  - Remains here indefinitely while held; the counter is frozen.
- WAIT_GAP:
  - rise -> SECOND, counter <= 1. Rise takes priority over timeout when both occur in the same cycle.
  - btn low and counter == GAP_CYCLES-1 -> short_press, IDLE.
  - Otherwise counter++.
- SECOND:
  - fall -> double_click, IDLE.
  - btn high and counter == LONG_CYCLES-1 -> long_press, LONG_HELD. The first tap is discarded; no short_press is emitted.
  - Otherwise counter++.
- Event exclusivity:
  - Per button gesture, at most one of short_press, long_press or double_click fires.
  - Two classification pulses are never high in the same cycle.
  - press_edge or release_edge may coincide with a classification pulse.
- Counter never wraps: the width guarantees headroom, and the counter only increments in PRESSED, WAIT_GAP and SECOND below their thresholds.
- Reset asserted mid-gesture aborts it: no pending pulse is emitted and state returns to IDLE immediately.
- busy = (state != IDLE), registered with state.

Test Plan:
- LONG=8, GAP=5:
  - Reset, btn_level low: all outputs 0, busy 0.
  - Hold high 3 cycles, then low: press_edge then release_edge pulse.
  - short_press pulses exactly once, 5 cycles after the release sample.
  - busy drops in the same cycle as short_press.
- LONG=8: hold btn_level high 20 cycles.
  - long_press pulses once, one cycle after the 8th high sample.
  - No further events, including on release; only release_edge fires.
- High 2, low 3, high 2, low: double_click pulses one cycle after the second fall; no short_press is emitted.
- High 2, low exactly 4 cycles, then rise coinciding with the timeout cycle: rise wins, and the gesture ends in double_click on release.
- High 2, low 2, then second press held 10 cycles: long_press only; no short_press or double_click.
- Reset with btn_level held high, then release reset: no press_edge.
  - Then release the button and press 2 cycles: release_edge, press_edge, release_edge, then short_press.
- Reset asserted during WAIT_GAP: outputs go 0 immediately, no short_press after reset release, busy 0.

Source files
------------

// File: rtl/button_event_decoder.sv
// Purpose: classify a debounced button level into one-shot edge, short, long and double-click strobes.
// Latency: every strobe is registered and appears one cycle after the sampling edge that decided it.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses and consumers must take them as they come.
module button_event_decoder #(
  parameter int LONG_CYCLES = 100_000_000,
  parameter int GAP_CYCLES  = 25_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_level,
  output logic press_edge,
  output logic release_edge,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
);

  // One counter serves every timed state, so it is sized for the longer of the two windows
  // plus a spare bit of headroom.
  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_LONG_HELD,
    ST_WAIT_GAP,
    ST_SECOND
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             btn_q;
  logic             rise;
  logic             fall;

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

  // Edge detector. btn_q resets high so that a button held through reset release
  // does not register as a fresh press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q        <= 1'b1;
      press_edge   <= 1'b0;
      release_edge <= 1'b0;
    end else begin
      btn_q        <= btn_level;
      press_edge   <= rise;
      release_edge <= fall;
    end
  end

  // Gesture classifier: tracks the press/gap/second-press sequence and issues exactly one
  // classification strobe per gesture; busy is registered alongside state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_PRESSED;
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end
        end

        ST_PRESSED: begin
          if (fall) begin
            state <= ST_WAIT_GAP;
            cnt   <= CNT_ONE;
          end else if (btn_level) begin
            if (cnt == LONG_LAST) begin
              long_press <= 1'b1;
              state      <= ST_LONG_HELD;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end

        // Counter is deliberately left frozen here; the gesture is already classified.
        ST_LONG_HELD: begin
          if (fall) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        // A new press on the very cycle the gap expires still counts as the second tap.
        ST_WAIT_GAP: begin
          if (rise) begin
            state <= ST_SECOND;
            cnt   <= CNT_ONE;
          end else if (!btn_level) begin
            if (cnt == GAP_LAST) begin
              short_press <= 1'b1;
              state       <= ST_IDLE;
              busy        <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end

        // Holding the second press too long turns the whole gesture into a long press;
        // the first tap is dropped without a short_press.
        ST_SECOND: begin
          if (fall) begin
            double_click <= 1'b1;
            state        <= ST_IDLE;
            busy         <= 1'b0;
          end else if (btn_level) begin
            if (cnt == LONG_LAST) begin
              long_press <= 1'b1;
              state      <= ST_LONG_HELD;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
